// File: rtl/camera_frame_ctrl_if.sv
// Camera-side and RAM-write-side signal bundle for camera_frame_ctrl.
// The slave modport is the sequencer; the master modport is whoever drives the camera pins and consumes writes.
interface camera_frame_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              cap_req;
  logic              err_clr;
  logic              VSYNC;
  logic              HREF;
  logic [7:0]        cam_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              bank;
  logic              frame_done;
  logic              cap_busy;
  logic              err_geom;
  logic [7:0]        frame_cnt;

  modport master (
    output cap_req, err_clr, VSYNC, HREF, cam_d,
    input  wr_en, wr_addr, wr_data, bank, frame_done, cap_busy, err_geom, frame_cnt
  );

  modport slave (
    input  cap_req, err_clr, VSYNC, HREF, cam_d,
    output wr_en, wr_addr, wr_data, bank, frame_done, cap_busy, err_geom, frame_cnt
  );
endinterface

// File: rtl/camera_frame_ctrl.sv
// Frame sequencer: aligns capture to VSYNC/HREF, packs bytes into 32-bit words and
// writes them into a ping-pong pair of RAM banks, flagging geometry errors.
module camera_frame_ctrl #(
  parameter int H_BYTES = 640,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 16
) (
  input  logic                PCLK,
  input  logic                HRESETn,
  camera_frame_ctrl_if.slave  cam
);

  localparam int BC_W = $clog2(H_BYTES) + 1;
  localparam int LC_W = $clog2(V_LINES) + 1;
  localparam int WC_W = ADDR_W - 1;

  localparam logic [BC_W-1:0] BC_H   = BC_W'(H_BYTES);
  localparam logic [BC_W-1:0] BC_MAX = {BC_W{1'b1}};
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);
  localparam logic [LC_W-1:0] LC_V   = LC_W'(V_LINES);
  localparam logic [LC_W-1:0] LC_MAX = {LC_W{1'b1}};
  localparam logic [LC_W-1:0] LC_ONE = LC_W'(1);
  localparam logic [WC_W-1:0] WC_MAX = {WC_W{1'b1}};
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_CAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_r_q, href_r_q, vsync_p_q, href_p_q;
  logic [7:0]        d_r_q;
  logic [23:0]       pack_q, pack_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              bank_q, bank_d;
  logic              frame_done_q, frame_done_d;
  logic              cap_busy_q, cap_busy_d;
  logic              err_q, err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic vs_rise, vs_fall, href_fall, in_cap, take, group_end, line_end, frame_end, err_set;

  assign vs_rise   = vsync_r_q & ~vsync_p_q;
  assign vs_fall   = ~vsync_r_q & vsync_p_q;
  assign href_fall = ~href_r_q & href_p_q;
  assign in_cap    = (state_q == S_CAP);
  assign take      = in_cap & href_r_q;
  assign group_end = take & (byte_cnt_q[1:0] == 2'd3);
  assign line_end  = in_cap & href_fall;
  assign frame_end = in_cap & vs_rise;

  // Input stage: one register on the camera pins plus a delayed copy for edge detection.
  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vsync_r_q <= 1'b0;
      href_r_q  <= 1'b0;
      d_r_q     <= 8'd0;
      vsync_p_q <= 1'b0;
      href_p_q  <= 1'b0;
    end else begin
      vsync_r_q <= cam.VSYNC;
      href_r_q  <= cam.HREF;
      d_r_q     <= cam.cam_d;
      vsync_p_q <= vsync_r_q;
      href_p_q  <= href_r_q;
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a request drop only aborts before capture has started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cam.cap_req) state_d = S_ARM;
        else             state_d = S_IDLE;
      end
      S_ARM: begin
        if (!cam.cap_req)   state_d = S_IDLE;
        else if (vsync_r_q) state_d = S_WAIT;
        else                state_d = S_ARM;
      end
      S_WAIT: begin
        if (!cam.cap_req) state_d = S_IDLE;
        else if (vs_fall) state_d = S_CAP;
        else              state_d = S_WAIT;
      end
      S_CAP: begin
        if (vs_rise) state_d = S_DONE;
        else         state_d = S_CAP;
      end
      S_DONE: begin
        if (cam.cap_req) state_d = S_WAIT;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the registered copies line up with the state.
  always_comb begin
    frame_done_d = (state_d == S_DONE);
    cap_busy_d   = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_CAP);
    bank_d       = bank_q ^ frame_done_d;
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 8'd1;
    else              frame_cnt_d = frame_cnt_q;
  end

  // Datapath: byte packing, write generation, counters and geometry checks.
  always_comb begin
    pack_d     = pack_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_set    = 1'b0;

    if (state_q == S_WAIT) begin
      byte_cnt_d = {BC_W{1'b0}};
      line_cnt_d = {LC_W{1'b0}};
      word_cnt_d = {WC_W{1'b0}};
      ovf_d      = 1'b0;
    end else if (take) begin
      pack_d = {d_r_q, pack_q[23:8]};
      if (byte_cnt_q == BC_MAX) byte_cnt_d = byte_cnt_q;
      else                      byte_cnt_d = byte_cnt_q + BC_ONE;
    end else if (line_end) begin
      // A trailing partial group is simply dropped: the packer is overwritten next line.
      byte_cnt_d = {BC_W{1'b0}};
      if (line_cnt_q == LC_MAX) line_cnt_d = line_cnt_q;
      else                      line_cnt_d = line_cnt_q + LC_ONE;
      if (byte_cnt_q != BC_H)   err_set    = 1'b1;
      else                      err_set    = 1'b0;
    end else begin
      pack_d = pack_q;
    end

    // Once the last word of the bank is written, later words are dropped rather than wrapping.
    if (group_end) begin
      if (ovf_q) begin
        err_set = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = {bank_q, word_cnt_q};
        wr_data_d = {d_r_q, pack_q};
        if (word_cnt_q == WC_MAX) ovf_d      = 1'b1;
        else                      word_cnt_d = word_cnt_q + WC_ONE;
      end
    end else begin
      wr_en_d = 1'b0;
    end

    if (frame_end && (line_cnt_q != LC_V)) err_set = 1'b1;
    else                                   err_set = err_set;

    if (err_set)          err_d = 1'b1;
    else if (cam.err_clr) err_d = 1'b0;
    else                  err_d = err_q;
  end

  // Datapath and output registers.
  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pack_q       <= 24'd0;
      byte_cnt_q   <= {BC_W{1'b0}};
      line_cnt_q   <= {LC_W{1'b0}};
      word_cnt_q   <= {WC_W{1'b0}};
      ovf_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= 32'd0;
      bank_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cap_busy_q   <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      pack_q       <= pack_d;
      byte_cnt_q   <= byte_cnt_d;
      line_cnt_q   <= line_cnt_d;
      word_cnt_q   <= word_cnt_d;
      ovf_q        <= ovf_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      bank_q       <= bank_d;
      frame_done_q <= frame_done_d;
      cap_busy_q   <= cap_busy_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign cam.wr_en      = wr_en_q;
  assign cam.wr_addr    = wr_addr_q;
  assign cam.wr_data    = wr_data_q;
  assign cam.bank       = bank_q;
  assign cam.frame_done = frame_done_q;
  assign cam.cap_busy   = cap_busy_q;
  assign cam.err_geom   = err_q;
  assign cam.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_camera_frame_ctrl.sv
// Directed bench for camera_frame_ctrl with an 8-byte x 2-line frame geometry.
module tb_camera_frame_ctrl;
  localparam int HB = 8;
  localparam int VL = 2;
  localparam int AW = 16;

  logic PCLK = 1'b0;
  logic HRESETn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   b4_cyc = 0;
  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];
  int            wq_cyc[$];

  camera_frame_ctrl_if #(.ADDR_W(AW)) cam_if ();

  camera_frame_ctrl #(.H_BYTES(HB), .V_LINES(VL), .ADDR_W(AW)) dut (
    .PCLK   (PCLK),
    .HRESETn(HRESETn),
    .cam    (cam_if)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Write/frame_done recorder, sampled mid-cycle.
  always @(negedge PCLK) begin
    if (cam_if.wr_en === 1'b1) begin
      wq_addr.push_back(cam_if.wr_addr);
      wq_data.push_back(cam_if.wr_data);
      wq_cyc.push_back(cyc);
    end
    if (cam_if.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    HRESETn = 1'b0;
    cam_if.HREF = 1'b0;
    cam_if.err_clr = 1'b0;
    tick(2);
    HRESETn = 1'b1;
    tick(1);
  endtask

  task automatic start_frame();
    cam_if.VSYNC = 1'b1;
    tick(3);
    cam_if.VSYNC = 1'b0;
    tick(3);
  endtask

  task automatic send_line(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      cam_if.HREF = 1'b1;
      cam_if.cam_d = first + 8'(i);
      if (i == 3) b4_cyc = cyc;
    end
    @(negedge PCLK);
    cam_if.HREF = 1'b0;
    cam_if.cam_d = 8'h00;
  endtask

  task automatic full_frame(input int nlines, input logic [7:0] first);
    start_frame();
    for (int l = 0; l < nlines; l++) begin
      send_line(HB, first + 8'(l * HB));
      tick(3);
    end
    cam_if.VSYNC = 1'b1;
    tick(5);
  endtask

  task automatic err_pulse();
    @(negedge PCLK);
    cam_if.err_clr = 1'b1;
    @(negedge PCLK);
    cam_if.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (cam_if.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0h exp 0", cam_if.wr_en); end
    checks++; if (cam_if.wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_wr_addr got %0h exp 0", cam_if.wr_addr); end
    checks++; if (cam_if.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", cam_if.wr_data); end
    checks++; if (cam_if.bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %0h exp 0", cam_if.bank); end
    checks++; if (cam_if.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0h exp 0", cam_if.frame_done); end
    checks++; if (cam_if.cap_busy !== 1'b0) begin errors++; $display("FAIL reset_cap_busy got %0h exp 0", cam_if.cap_busy); end
    checks++; if (cam_if.err_geom !== 1'b0) begin errors++; $display("FAIL reset_err_geom got %0h exp 0", cam_if.err_geom); end
    checks++; if (cam_if.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", cam_if.frame_cnt); end
    HRESETn = 1'b1;
    tick(3);
    checks++; if (cam_if.cap_busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got %0h exp 0", cam_if.cap_busy); end
  endtask

  task automatic test_nominal();
    logic [31:0] exp_d[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    int fd0;
    int lat_ref;
    clear_q();
    fd0 = fd_cnt;
    cam_if.cap_req = 1'b1;
    start_frame();
    checks++; if (cam_if.cap_busy !== 1'b1) begin errors++; $display("FAIL nominal_busy got %0h exp 1", cam_if.cap_busy); end
    send_line(HB, 8'h01);
    lat_ref = b4_cyc;
    tick(3);
    send_line(HB, 8'h09);
    tick(3);
    cam_if.VSYNC = 1'b1;
    tick(5);
    checks++; if (wq_addr.size() !== 4) begin errors++; $display("FAIL nominal_nwrites got %0d exp 4", wq_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wq_addr[i] !== 16'(i)) begin errors++; $display("FAIL nominal_addr%0d got %0h exp %0h", i, wq_addr[i], i); end
      checks++; if (wq_data[i] !== exp_d[i]) begin errors++; $display("FAIL nominal_data%0d got %0h exp %0h", i, wq_data[i], exp_d[i]); end
    end
    checks++; if (wq_cyc[0] !== lat_ref + 2) begin errors++; $display("FAIL write_latency got %0d exp %0d", wq_cyc[0], lat_ref + 2); end
    checks++; if (wq_cyc[1] - wq_cyc[0] !== 4) begin errors++; $display("FAIL back_to_back_spacing got %0d exp 4", wq_cyc[1] - wq_cyc[0]); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL nominal_frame_done got %0d exp 1", fd_cnt - fd0); end
    checks++; if (cam_if.bank !== 1'b1) begin errors++; $display("FAIL nominal_bank got %0h exp 1", cam_if.bank); end
    checks++; if (cam_if.frame_cnt !== 8'd1) begin errors++; $display("FAIL nominal_frame_cnt got %0d exp 1", cam_if.frame_cnt); end
    checks++; if (cam_if.err_geom !== 1'b0) begin errors++; $display("FAIL nominal_err got %0h exp 0", cam_if.err_geom); end
  endtask

  task automatic test_continuous();
    int fd0;
    apply_reset();
    clear_q();
    fd0 = fd_cnt;
    cam_if.cap_req = 1'b1;
    for (int f = 0; f < 3; f++) full_frame(2, 8'h01);
    checks++; if (wq_addr.size() !== 12) begin errors++; $display("FAIL cont_nwrites got %0d exp 12", wq_addr.size()); end
    checks++; if (wq_addr[0] !== 16'h0000) begin errors++; $display("FAIL cont_base0 got %0h exp 0000", wq_addr[0]); end
    checks++; if (wq_addr[4] !== 16'h8000) begin errors++; $display("FAIL cont_base1 got %0h exp 8000", wq_addr[4]); end
    checks++; if (wq_addr[7] !== 16'h8003) begin errors++; $display("FAIL cont_last1 got %0h exp 8003", wq_addr[7]); end
    checks++; if (wq_addr[8] !== 16'h0000) begin errors++; $display("FAIL cont_base2 got %0h exp 0000", wq_addr[8]); end
    checks++; if (cam_if.frame_cnt !== 8'd3) begin errors++; $display("FAIL cont_frame_cnt got %0d exp 3", cam_if.frame_cnt); end
    checks++; if (cam_if.bank !== 1'b1) begin errors++; $display("FAIL cont_bank got %0h exp 1", cam_if.bank); end
    checks++; if (fd_cnt - fd0 !== 3) begin errors++; $display("FAIL cont_frame_done got %0d exp 3", fd_cnt - fd0); end
  endtask

  task automatic test_short_line();
    clear_q();
    start_frame();
    send_line(6, 8'h01);
    tick(3);
    checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL short_nwrites got %0d exp 1", wq_addr.size()); end
    checks++; if (wq_addr[0] !== 16'h8000) begin errors++; $display("FAIL short_addr got %0h exp 8000", wq_addr[0]); end
    checks++; if (cam_if.err_geom !== 1'b1) begin errors++; $display("FAIL short_err_set got %0h exp 1", cam_if.err_geom); end
    err_pulse();
    tick(1);
    checks++; if (cam_if.err_geom !== 1'b0) begin errors++; $display("FAIL short_err_clr got %0h exp 0", cam_if.err_geom); end
    send_line(6, 8'h11);
    err_pulse();
    checks++; if (cam_if.err_geom !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %0h exp 1", cam_if.err_geom); end
    tick(3);
    cam_if.VSYNC = 1'b1;
    tick(5);
    checks++; if (wq_data[1] !== 32'h14131211) begin errors++; $display("FAIL short_partial_drop got %0h exp 14131211", wq_data[1]); end
    err_pulse();
  endtask

  task automatic test_wrong_lines();
    int fd0;
    clear_q();
    fd0 = fd_cnt;
    start_frame();
    for (int l = 0; l < 3; l++) begin
      send_line(HB, 8'h20);
      tick(3);
    end
    checks++; if (cam_if.err_geom !== 1'b0) begin errors++; $display("FAIL lines_err_early got %0h exp 0", cam_if.err_geom); end
    cam_if.VSYNC = 1'b1;
    tick(1);
    checks++; if (cam_if.frame_done !== 1'b0) begin errors++; $display("FAIL done_early got %0h exp 0", cam_if.frame_done); end
    tick(1);
    checks++; if (cam_if.frame_done !== 1'b1) begin errors++; $display("FAIL done_timing got %0h exp 1", cam_if.frame_done); end
    checks++; if (cam_if.err_geom !== 1'b1) begin errors++; $display("FAIL lines_err got %0h exp 1", cam_if.err_geom); end
    checks++; if (cam_if.bank !== 1'b1) begin errors++; $display("FAIL lines_bank got %0h exp 1", cam_if.bank); end
    tick(4);
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL lines_frame_done got %0d exp 1", fd_cnt - fd0); end
    checks++; if (wq_addr.size() !== 6) begin errors++; $display("FAIL lines_nwrites got %0d exp 6", wq_addr.size()); end
    err_pulse();
  endtask

  task automatic test_req_drop();
    int fd0;
    clear_q();
    fd0 = fd_cnt;
    start_frame();
    send_line(HB, 8'h01);
    tick(3);
    cam_if.cap_req = 1'b0;
    send_line(HB, 8'h09);
    tick(3);
    cam_if.VSYNC = 1'b1;
    tick(5);
    checks++; if (wq_addr.size() !== 4) begin errors++; $display("FAIL drop_nwrites got %0d exp 4", wq_addr.size()); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL drop_frame_done got %0d exp 1", fd_cnt - fd0); end
    checks++; if (cam_if.cap_busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %0h exp 0", cam_if.cap_busy); end
    checks++; if (cam_if.frame_cnt !== 8'd6) begin errors++; $display("FAIL drop_frame_cnt got %0d exp 6", cam_if.frame_cnt); end
    full_frame(2, 8'h01);
    checks++; if (wq_addr.size() !== 4) begin errors++; $display("FAIL drop_next_nwrites got %0d exp 4", wq_addr.size()); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL drop_next_done got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid_line();
    cam_if.cap_req = 1'b1;
    tick(2);
    start_frame();
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      cam_if.HREF = 1'b1;
      cam_if.cam_d = 8'hA0 + 8'(i);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if (cam_if.wr_data !== 32'h0) begin errors++; $display("FAIL midrst_wr_data got %0h exp 0", cam_if.wr_data); end
    checks++; if (cam_if.wr_addr !== 16'h0) begin errors++; $display("FAIL midrst_wr_addr got %0h exp 0", cam_if.wr_addr); end
    checks++; if (cam_if.cap_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0h exp 0", cam_if.cap_busy); end
    checks++; if (cam_if.frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt got %0d exp 0", cam_if.frame_cnt); end
    checks++; if (cam_if.bank !== 1'b0) begin errors++; $display("FAIL midrst_bank got %0h exp 0", cam_if.bank); end
    @(negedge PCLK);
    HRESETn = 1'b1;
    clear_q();
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      cam_if.cam_d = 8'hB0 + 8'(i);
    end
    @(negedge PCLK);
    cam_if.HREF = 1'b0;
    tick(3);
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL midrst_no_write got %0d exp 0", wq_addr.size()); end
    checks++; if (cam_if.cap_busy !== 1'b1) begin errors++; $display("FAIL midrst_armed got %0h exp 1", cam_if.cap_busy); end
    full_frame(2, 8'h01);
    checks++; if (wq_addr.size() !== 4) begin errors++; $display("FAIL midrst_nwrites got %0d exp 4", wq_addr.size()); end
    checks++; if (wq_addr[0] !== 16'h0000) begin errors++; $display("FAIL midrst_addr0 got %0h exp 0000", wq_addr[0]); end
    checks++; if (wq_data[3] !== 32'h100F0E0D) begin errors++; $display("FAIL midrst_data3 got %0h exp 100f0e0d", wq_data[3]); end
    checks++; if (cam_if.frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_frame_cnt got %0d exp 1", cam_if.frame_cnt); end
  endtask

  initial begin
    HRESETn = 1'b0;
    cam_if.cap_req = 1'b0;
    cam_if.err_clr = 1'b0;
    cam_if.VSYNC = 1'b1;
    cam_if.HREF = 1'b0;
    cam_if.cam_d = 8'h00;
    test_reset();
    test_nominal();
    test_continuous();
    test_short_line();
    test_wrong_lines();
    test_req_drop();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_frame_ctrl.md
# camera_frame_ctrl

Frame-level sequencer for the camera capture path. It runs in the camera PCLK domain and arms capture on a software request. It aligns capture to VSYNC/HREF frame boundaries and packs incoming bytes into 32-bit words. It generates dual-port RAM write strobes and addresses into a ping-pong pair of frame banks, and reports frame completion, bank ownership and geometry errors to the AHB-side status logic.

## Interface
Parameters:
- H_BYTES, 640: bytes per line (320 RGB565 pixels); must be a multiple of 4.
- V_LINES, 240: lines per frame.
- ADDR_W, 16: RAM word-address width; MSB selects the bank.

Ports:
- PCLK  in  1  camera pixel clock.
- HRESETn  in  1  asynchronous, active-low reset.
- cap_req  in  1  capture enable level, already synchronised to PCLK.
- err_clr  in  1  one-cycle pulse that clears err_geom.
- VSYNC  in  1  camera vertical sync; high = blanking.
- HREF  in  1  camera line-valid.
- cam_d  in  8  camera data byte.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM word address: {bank, word_cnt}.
- wr_data  out  32  packed word; first byte of the group is in [7:0].
- bank  out  1  bank currently being written; the other bank holds the last complete frame.
- frame_done  out  1  one-cycle pulse at the end of each completed frame.
- cap_busy  out  1  high in ARM, WAIT_START and CAPTURE.
- err_geom  out  1  sticky geometry/overflow error.
- frame_cnt  out  8  count of completed frames; wraps at 255 -> 0.

## Operation
- Input stage: VSYNC, HREF and cam_d are registered once (vsync_r, href_r, d_r). href_q and vsync_q are a one-cycle delay of the registered values and are used for edge detection. The inputs are camera-synchronous, so no further synchronisation is applied.
- States:
  - IDLE: waits for cap_req=1, then goes to ARM.
  - ARM: waits for vsync_r=1 (blanking), then goes to WAIT_START.
  - WAIT_START: goes to CAPTURE on the vsync_r falling edge. Clears byte_cnt, word_cnt and line_cnt.
  - CAPTURE: see the capture, line-end and frame-end rules below.
  - DONE: lasts exactly one cycle. Asserts frame_done, toggles bank and increments frame_cnt. Next state is WAIT_START if cap_req=1, otherwise IDLE.
- Mid-capture request drop: cap_req falling during CAPTURE does not abort. The current frame completes, then the FSM goes to IDLE. cap_req falling in ARM or WAIT_START returns the FSM to IDLE immediately.
- Byte capture: in CAPTURE, each cycle with href_r=1 is one byte.
  - d_r shifts into a 32-bit packer ({d_r, pack[31:8]}) and byte_cnt increments.
  - When the 4th byte of a group is taken (byte_cnt[1:0]==3), the next cycle asserts wr_en for one cycle with wr_data equal to the packer and wr_addr = {bank, word_cnt}.
  - word_cnt increments in the same cycle as that wr_en.
- Line end: on the href_r falling edge in CAPTURE:
  - byte_cnt != H_BYTES sets err_geom.
  - A partial trailing group (fewer than 4 bytes) is discarded.
  - line_cnt increments and byte_cnt clears.
- Frame end: on the vsync_r rising edge in CAPTURE:
  - line_cnt != V_LINES sets err_geom.
  - The FSM goes to DONE.
  - If a write is pending that same cycle, it still issues.
- Overflow: when word_cnt = 2^(ADDR_W-1)-1 has been written, further writes in that frame are suppressed (no wrap into the other bank) and err_geom is set.
- err_geom priority: if set and err_clr occur in the same cycle, set wins.
- Widths: byte_cnt is clog2(H_BYTES)+1 bits and saturates at its maximum; line_cnt is clog2(V_LINES)+1 bits and saturates.

## Timing
- Reset values: wr_en, wr_addr, wr_data, bank, frame_done, cap_busy, err_geom and frame_cnt are all 0. FSM = IDLE, all counters 0.
- Reset asserted mid-frame: every output and counter returns to 0 asynchronously. After release, the FSM re-arms through ARM, so no partial frame is written.
- Write latency: a byte present on cam_d at edge n is registered at n+1. For the 4th byte of a group, wr_en is high in the cycle after edge n+2.
- Back-to-back groups produce one wr_en every 4 PCLK cycles while HREF is held high.
- frame_done occurs 2 cycles after the VSYNC rising edge on the pins.
- bank toggles in the same cycle frame_done is high. The first write of the next frame uses the new bank.
- cap_busy is low only in IDLE and DONE.

## Test plan
- Nominal frame (H_BYTES=8, V_LINES=2): cap_req=1, VSYNC 1->0, two HREF lines of 8 bytes each (0x01..0x10).
  - Required: 4 writes to addrs 0..3 with data 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D.
  - Then frame_done once, bank=1, frame_cnt=1, err_geom=0.
- Continuous mode: hold cap_req for 3 frames.
  - Required: writes alternate between bases 0x0000 and 0x8000; frame_cnt=3; bank=1.
- Short line: send a 6-byte line.
  - Required: 1 write only, err_geom=1 after the HREF fall.
  - Then err_clr pulse -> err_geom=0.
  - err_clr in the same cycle as a new error -> err_geom remains 1.
- Wrong line count: 3 lines where V_LINES=2.
  - Required: err_geom=1 at the VSYNC rise; frame_done still pulses.
- Request dropped mid-frame: cap_req falls in CAPTURE.
  - Required: the frame completes, frame_done pulses, the FSM ends in IDLE, and no writes occur on the next frame.
- Reset mid-line: HRESETn low during HREF.
  - Required: outputs 0 immediately.
  - After release with cap_req=1 mid-frame, no writes until the next VSYNC high->low sequence.
